uart_byte_tx: RTL

// Host-side UART transmitter that drives the serial rx input of the tiniest-gpu core.

---
 rtl/uart_byte_tx_if.sv | 18 +
 rtl/uart_byte_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between a host and the UART transmitter.
interface uart_byte_tx_if;
    logic [7:0] tx_data_in;
    logic       tx_data_valid_in;
    logic       tx_ready_out;

    modport master (
        output tx_data_in,
        output tx_data_valid_in,
        input  tx_ready_out
    );

    modport slave (
        input  tx_data_in,
        input  tx_data_valid_in,
        output tx_ready_out
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a small byte FIFO, LSB first, idle-high line.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 174,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clk_20,
    input  logic          reset,
    uart_byte_tx_if.slave host,
    output logic          tx_out,
    output logic          busy_out
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            ready_q;
    logic            push, pop, empty, full_d;
    logic [7:0]      head;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            baud_last;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = host.tx_data_valid_in && ready_q;
    assign wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop};
    // Ready is registered from next-cycle occupancy, so valid never reaches ready.
    assign full_d   = (wr_ptr_d[PtrW] != rd_ptr_d[PtrW]) &&
                      (wr_ptr_d[PtrW-1:0] == rd_ptr_d[PtrW-1:0]);
    assign head     = mem_q[rd_ptr_q[PtrW-1:0]];

    assign host.tx_ready_out = ready_q;
    assign tx_out            = tx_q;
    assign busy_out          = (state_q != StIdle) || !empty;
    assign baud_last         = (baud_q == CntW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_20) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= host.tx_data_in;
        end
    end

    always_ff @(posedge clk_20) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= !full_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule
